game_flow_ctl: RTL and testbench
================================

// Module: game_flow_ctl
// PURPOSE
// Top-level game sequencer for the character controller: title -> play -> level fade -> win.
// Sits between keyboard decoder and character controller; gates the controller's key inputs,
// reset and clock-enable, watches its level output, and drives screen select, fade level and
// play timer to the VGA/overlay path. Also supplies the shared 100 Hz physics tick strobe.
// PARAMETERS
// CLK_FREQ   100_000_000  system clock frequency, Hz
// TICK_HZ    100          tick strobe rate, Hz; TICK_DIV = CLK_FREQ/TICK_HZ (integer, >=2)
// WIN_LEVEL  3            level value (2-bit) that ends the game
// PORTS
// clk         in   1   system clock
// rst         in   1   synchronous reset, active-high
// key_space   in   1   keyboard level, space
// key_left    in   1   keyboard level, left
// key_right   in   1   keyboard level, right
// key_esc     in   1   keyboard level, escape (used only with GAME_PAUSE_EN)
// level       in   2   current level from character controller
// char_space  out  1   gated space to character controller
// char_left   out  1   gated left to character controller
// char_right  out  1   gated right to character controller
// char_rst    out  1   reset to character controller, active-high
// char_en     out  1   clock enable to character controller
// screen      out  3   0 TITLE, 1 PLAY, 2 FADE, 3 WIN, 4 PAUSE
// fade_level  out  4   overlay darkness, 15 = black, 0 = clear
// tick        out  1   one-cycle strobe every TICK_DIV cycles
// timer_sec   out  16  elapsed play seconds
// BEHAVIOUR
// - Reset values: screen=0, char_rst=1, char_en=1, char_* keys=0, fade_level=0, tick=0, timer_sec=0.
//   rst in any state returns to TITLE on the next edge; tick counter restarts.
// - Tick: free-running counter 0..TICK_DIV-1. tick=1 when counter==TICK_DIV-1; first strobe
//   TICK_DIV cycles after rst deasserts.
// - Edges: each key registered (*_q); rise = key & ~key_q. State changes on the edge where rise
//   is seen, so screen moves 1 cycle after the key goes high. Level change = level != level_q.
// - char_* keys registered: char_x <= (state==PLAY) & key_x & armed. 1-cycle latency.
//   armed clears on TITLE->PLAY and sets once key_space is sampled low (applies to char_space only).
//   Holding space through game start therefore never triggers a jump.
// - TITLE: char_rst=1; keys gated. space rise -> PLAY, timer_sec cleared.
// - PLAY: char_rst=0; keys pass. Level change to WIN_LEVEL -> WIN.
//   Other level change -> FADE with fade_level=15.
// - FADE: keys gated, controller runs. fade_level decrements by 1 on each tick.
//   A tick with fade_level==0 -> PLAY (16 ticks total). A new level change restarts fade_level=15.
//   A change to WIN_LEVEL goes to WIN instead.
// - WIN: keys gated, char_rst=0, timer frozen. space rise -> TITLE (char_rst=1 next cycle).
// - Priority in one cycle: rst > level change > esc rise > space rise.
// - timer_sec: sub-counter counts ticks in PLAY and FADE only. On TICK_HZ ticks, timer_sec+1 and
//   sub-counter clears. Saturates at 16'hFFFF. Sub-counter clears with timer_sec.
// - fade_level=0 outside FADE; char_en=1 in all states except PAUSE.
// CONFIGURATION
// GAME_PAUSE_EN defined: esc rise in PLAY -> PAUSE (screen=4, char_en=0, keys gated).
//   In PAUSE, timer and sub-counter hold and level changes are ignored. esc rise -> PLAY.
//   armed is cleared on PAUSE->PLAY.
// GAME_PAUSE_EN undefined: key_esc ignored, PAUSE unreachable, char_en tied 1.
// TESTING (bench: CLK_FREQ=1000, TICK_HZ=100 -> TICK_DIV=10)
// 1 rst 3 cycles, key_space high 5 cycles -> screen=1 and char_rst=0 one cycle after rise;
//   char_space=0 throughout. Low then high again -> char_space=1 one cycle later.
// 2 PLAY, level 0->1 -> screen=2, fade_level=15, then 14..0 on successive ticks; screen=1 on 16th tick.
// 3 PLAY, level 2->3 -> screen=3, timer_sec frozen. Space rise -> screen=0, char_rst=1.
// 4 PLAY 250 ticks -> timer_sec=2. level 1->2 at fade_level=5 -> fade_level=15 restart.
// 5 GAME_PAUSE_EN: esc rise in PLAY -> screen=4, char_en=0, timer holds 50 ticks.
//   esc rise -> screen=1. Same cycle as level change -> FADE wins.
// 6 rst during FADE (fade_level=7) -> next cycle all outputs at reset values, tick 10 cycles later.

Source files
------------

// File: rtl/game_flow_ctl.sv
// Game sequencer: title -> play -> level fade -> win, gating the character controller.
// Define GAME_PAUSE_EN to add the escape-key pause screen.
module game_flow_ctl #(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int TICK_HZ   = 100,
   parameter int WIN_LEVEL = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_space,
   input  logic        key_left,
   input  logic        key_right,
   input  logic        key_esc,
   input  logic [1:0]  level,
   output logic        char_space,
   output logic        char_left,
   output logic        char_right,
   output logic        char_rst,
   output logic        char_en,
   output logic [2:0]  screen,
   output logic [3:0]  fade_level,
   output logic        tick,
   output logic [15:0] timer_sec
);

   localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
   localparam int TCW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SCW      = $clog2(TICK_HZ + 1);
   localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);
   localparam logic [SCW-1:0] SUB_LAST  = SCW'(TICK_HZ - 1);
   localparam logic [1:0]     WIN_LVL   = 2'(WIN_LEVEL);

   typedef enum logic [2:0] {
      S_TITLE = 3'd0,
      S_PLAY  = 3'd1,
      S_FADE  = 3'd2,
      S_WIN   = 3'd3,
      S_PAUSE = 3'd4
   } state_t;

   state_t           state;
   logic [TCW-1:0]   tick_cnt;
   logic [SCW-1:0]   sub_cnt;
   logic             space_q;
   logic [1:0]       level_q;
   logic             armed;
   logic             space_rise;
   logic             lvl_chg;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign screen     = state;
   assign space_rise = key_space & ~space_q;
   assign lvl_chg    = (level != level_q);

`ifdef GAME_PAUSE_EN
   logic esc_q;
   logic esc_rise;
   assign esc_rise = key_esc & ~esc_q;

   always_ff @(posedge clk) begin
      esc_q <= key_esc;
   end
`else
   logic unused_esc;
   assign unused_esc = key_esc;
   assign char_en    = 1'b1;
`endif

   // Edge-detect history tracks the inputs even through reset.
   always_ff @(posedge clk) begin
      space_q <= key_space;
      level_q <= level;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt <= '0;
         tick     <= 1'b0;
      end else begin
         tick     <= (tick_cnt == TICK_LAST);
         tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_TITLE;
         char_rst   <= 1'b1;
         char_space <= 1'b0;
         char_left  <= 1'b0;
         char_right <= 1'b0;
         fade_level <= '0;
         timer_sec  <= '0;
         sub_cnt    <= '0;
         armed      <= 1'b0;
`ifdef GAME_PAUSE_EN
         char_en    <= 1'b1;
`endif
      end else begin
         // A space held across game start must be released before it can jump.
         char_space <= (state == S_PLAY) && key_space && armed;
         char_left  <= (state == S_PLAY) && key_left;
         char_right <= (state == S_PLAY) && key_right;
         if (!key_space)
            armed <= 1'b1;

         if (tick && (state == S_PLAY || state == S_FADE)) begin
            if (sub_cnt == SUB_LAST) begin
               sub_cnt   <= '0;
               timer_sec <= sat_inc(timer_sec);
            end else begin
               sub_cnt <= sub_cnt + 1'b1;
            end
         end

         case (state)
            S_TITLE: begin
               if (space_rise) begin
                  state     <= S_PLAY;
                  char_rst  <= 1'b0;
                  armed     <= 1'b0;
                  timer_sec <= '0;
                  sub_cnt   <= '0;
               end
            end
            S_PLAY: begin
               if (lvl_chg) begin
                  if (level == WIN_LVL) begin
                     state <= S_WIN;
                  end else begin
                     state      <= S_FADE;
                     fade_level <= 4'd15;
                  end
               end
`ifdef GAME_PAUSE_EN
               else if (esc_rise) begin
                  state   <= S_PAUSE;
                  char_en <= 1'b0;
               end
`endif
            end
            S_FADE: begin
               if (lvl_chg) begin
                  if (level == WIN_LVL) begin
                     state      <= S_WIN;
                     fade_level <= '0;
                  end else begin
                     fade_level <= 4'd15;
                  end
               end else if (tick) begin
                  if (fade_level == 4'd0)
                     state <= S_PLAY;
                  else
                     fade_level <= fade_level - 4'd1;
               end
            end
            S_WIN: begin
               if (space_rise) begin
                  state    <= S_TITLE;
                  char_rst <= 1'b1;
               end
            end
`ifdef GAME_PAUSE_EN
            S_PAUSE: begin
               if (esc_rise) begin
                  state   <= S_PLAY;
                  char_en <= 1'b1;
                  armed   <= 1'b0;
               end
            end
`endif
            default: begin
               state      <= S_TITLE;
               char_rst   <= 1'b1;
               fade_level <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_game_flow_ctl.sv
// Bench for game_flow_ctl: vector table, directed multi-cycle sequences and a random run,
// all cross-checked every cycle against a behavioural model of the game rules.
module tb_game_flow_ctl;

   localparam int CLK_FREQ = 1000;
   localparam int TICK_HZ  = 100;
   localparam int TICK_DIV = CLK_FREQ / TICK_HZ;

   logic        clk = 1'b0;
   logic        rst, key_space, key_left, key_right, key_esc;
   logic [1:0]  level;
   logic        char_space, char_left, char_right, char_rst, char_en, tick;
   logic [2:0]  screen;
   logic [3:0]  fade_level;
   logic [15:0] timer_sec;

   game_flow_ctl #(.CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ), .WIN_LEVEL(3)) dut (
      .clk(clk), .rst(rst), .key_space(key_space), .key_left(key_left),
      .key_right(key_right), .key_esc(key_esc), .level(level),
      .char_space(char_space), .char_left(char_left), .char_right(char_right),
      .char_rst(char_rst), .char_en(char_en), .screen(screen), .fade_level(fade_level),
      .tick(tick), .timer_sec(timer_sec)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Behavioural model state: screen number, fade, total counted ticks, cycles since reset.
   bit         m_valid = 1'b0;
   int         m_scr, m_fade, m_play_ticks, m_since;
   bit         m_tick, m_armed, m_cs, m_cl, m_cr;
   bit         p_sp, p_esc;
   logic [1:0] p_lvl;

   typedef struct {
      bit rst, sp, lf;
      int scr;
      bit crst, cs, cl;
   } vec_t;
   vec_t tv [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (hex)", name, act, exp);
      end
   endtask

   function automatic logic [28:0] model_pack();
      int secs;
      secs = m_play_ticks / TICK_HZ;
      if (secs > 65535) secs = 65535;
      return {3'(m_scr), 4'(m_fade), 16'(secs), m_tick, (m_scr == 0), (m_scr != 4), m_cs, m_cl, m_cr};
   endfunction

   function automatic logic [28:0] dut_pack();
      return {screen, fade_level, timer_sec, tick, char_rst, char_en, char_space, char_left, char_right};
   endfunction

   task automatic model_edge();
      bit tick_ev, sr, er, lc, armed_old;
      int old;
      if (rst) begin
         m_scr = 0; m_fade = 0; m_play_ticks = 0; m_since = 0; m_tick = 0;
         m_armed = 0; m_cs = 0; m_cl = 0; m_cr = 0;
      end else begin
         tick_ev   = m_tick;
         old       = m_scr;
         armed_old = m_armed;
         sr = key_space && !p_sp;
         lc = (level != p_lvl);
`ifdef GAME_PAUSE_EN
         er = key_esc && !p_esc;
`else
         er = 1'b0;
`endif
         m_cs = (old == 1) && key_space && armed_old;
         m_cl = (old == 1) && key_left;
         m_cr = (old == 1) && key_right;
         if (!key_space) m_armed = 1;
         if (tick_ev && (old == 1 || old == 2)) m_play_ticks++;
         case (old)
            0: if (sr) begin m_scr = 1; m_play_ticks = 0; m_armed = 0; end
            1: begin
               if (lc) begin
                  if (level == 2'd3) m_scr = 3;
                  else begin m_scr = 2; m_fade = 15; end
               end else if (er) m_scr = 4;
            end
            2: begin
               if (lc) begin
                  if (level == 2'd3) begin m_scr = 3; m_fade = 0; end
                  else m_fade = 15;
               end else if (tick_ev) begin
                  if (m_fade == 0) m_scr = 1;
                  else m_fade--;
               end
            end
            3: if (sr) m_scr = 0;
            4: if (er) begin m_scr = 1; m_armed = 0; end
            default: ;
         endcase
         m_since++;
         m_tick = (m_since % TICK_DIV == 0);
      end
      p_sp    = key_space;
      p_esc   = key_esc;
      p_lvl   = level;
      m_valid = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      if (m_valid) chk("model", 32'(dut_pack()), 32'(model_pack()));
   endtask

   // Advance to the edge that consumes the next tick strobe.
   task automatic tick_edge(input string name);
      int n;
      n = 0;
      while (tick !== 1'b1 && n < 2 * TICK_DIV) begin
         step();
         n++;
      end
      if (tick !== 1'b1) chk({name, "_tick_timeout"}, 32'(tick), 1);
      step();
   endtask

   task automatic press_space();
      key_space = 1'b0;
      step();
      key_space = 1'b1;
      step();
      key_space = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //           rst   sp    lf   scr  crst  cs    cl
      tv[0]  = '{1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0};
      tv[1]  = '{1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0};
      tv[2]  = '{1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0};
      tv[3]  = '{1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0};
      tv[4]  = '{1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0};
      tv[5]  = '{1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b1};
      tv[6]  = '{1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0};
      tv[7]  = '{1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0};
      tv[8]  = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
      tv[9]  = '{1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0};
      tv[10] = '{1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b1};
      tv[11] = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0};

      rst = 1'b1; key_space = 1'b0; key_left = 1'b0; key_right = 1'b0; key_esc = 1'b0; level = 2'd0;

      // Reset, game start with a held space, then a real jump.
      for (int i = 0; i < 12; i++) begin
         rst       = tv[i].rst;
         key_space = tv[i].sp;
         key_left  = tv[i].lf;
         step();
         chk($sformatf("t1_%0d_screen", i), 32'(screen), tv[i].scr);
         chk($sformatf("t1_%0d_char_rst", i), 32'(char_rst), 32'(tv[i].crst));
         chk($sformatf("t1_%0d_char_space", i), 32'(char_space), 32'(tv[i].cs));
         chk($sformatf("t1_%0d_char_left", i), 32'(char_left), 32'(tv[i].cl));
      end

      // Level change starts a 16-tick fade.
      level = 2'd1;
      step();
      chk("t2_screen_fade", 32'(screen), 2);
      chk("t2_fade_start", 32'(fade_level), 15);
      for (int k = 14; k >= 0; k--) begin
         tick_edge("t2");
         chk($sformatf("t2_fade_%0d", k), 32'(fade_level), 32'(k));
         chk($sformatf("t2_screen_%0d", k), 32'(screen), 2);
      end
      tick_edge("t2_last");
      chk("t2_back_to_play", 32'(screen), 1);
      chk("t2_fade_clear", 32'(fade_level), 0);

      // Reach level 2, then win.
      level = 2'd2;
      step();
      repeat (16) tick_edge("t3");
      chk("t3_play_again", 32'(screen), 1);
      level = 2'd3;
      step();
      chk("t3_win", 32'(screen), 3);
      chk("t3_win_fade", 32'(fade_level), 0);
      repeat (30) step();
      chk("t3_win_timer", 32'(timer_sec), 0);
      press_space();
      chk("t3_title", 32'(screen), 0);
      chk("t3_title_rst", 32'(char_rst), 1);

      // Long play for the seconds timer, then a fade restart.
      press_space();
      chk("t4_play", 32'(screen), 1);
      chk("t4_timer_clear", 32'(timer_sec), 0);
      repeat (2500) step();
      chk("t4_timer_2s", 32'(timer_sec), 2);
      level = 2'd1;
      step();
      repeat (10) tick_edge("t4");
      chk("t4_fade_5", 32'(fade_level), 5);
      level = 2'd2;
      step();
      chk("t4_fade_restart", 32'(fade_level), 15);
      chk("t4_still_fade", 32'(screen), 2);
      level = 2'd3;
      step();
      chk("t4_fade_to_win", 32'(screen), 3);
      chk("t4_win_fade", 32'(fade_level), 0);

      // Escape handling.
      press_space();
      press_space();
      chk("t5_play", 32'(screen), 1);
      repeat (950) step();
`ifdef GAME_PAUSE_EN
      key_esc = 1'b1;
      step();
      chk("t5_pause", 32'(screen), 4);
      chk("t5_pause_en", 32'(char_en), 0);
      repeat (500) step();
      chk("t5_timer_held", 32'(timer_sec), 0);
      level = 2'd1;
      step();
      chk("t5_pause_ignores_level", 32'(screen), 4);
      key_esc = 1'b0;
      step();
      key_esc = 1'b1;
      step();
      chk("t5_resume", 32'(screen), 1);
      chk("t5_resume_en", 32'(char_en), 1);
      key_esc = 1'b0;
      step();
      key_esc = 1'b1;
      level   = 2'd2;
      step();
      chk("t5_level_beats_esc", 32'(screen), 2);
      key_esc = 1'b0;
`else
      key_esc = 1'b1;
      step();
      chk("t5_esc_ignored", 32'(screen), 1);
      chk("t5_en_tied", 32'(char_en), 1);
      key_esc = 1'b0;
      level   = 2'd2;
      step();
      chk("t5_fade", 32'(screen), 2);
`endif

      // Reset in the middle of a fade.
      repeat (8) tick_edge("t6");
      chk("t6_fade_7", 32'(fade_level), 7);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t6_screen", 32'(screen), 0);
      chk("t6_char_rst", 32'(char_rst), 1);
      chk("t6_char_en", 32'(char_en), 1);
      chk("t6_keys", 32'({char_space, char_left, char_right}), 0);
      chk("t6_fade", 32'(fade_level), 0);
      chk("t6_tick", 32'(tick), 0);
      chk("t6_timer", 32'(timer_sec), 0);
      for (int i = 1; i <= 10; i++) begin
         step();
         chk($sformatf("t6_tick_after_%0d", i), 32'(tick), 32'(i == 10));
      end

      // Random play against the model.
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (4000) begin
         rst = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 7) == 0) key_space = ~key_space;
         key_left  = 1'($urandom_range(0, 1));
         key_right = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 29) == 0) key_esc = ~key_esc;
         if ($urandom_range(0, 149) == 0) level = 2'($urandom_range(0, 3));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
